// File: rtl/athena_reg_arbiter.sv
// Round-robin arbiter sharing one register-slave bus between the host bridge (0)
// and the settings engine (1); one transaction in flight, reads guarded by a timeout.
module athena_reg_arbiter #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                TIMEOUT      = 16,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             m_req,
    input  logic [1:0]             m_wr,
    input  logic [1:0][ADDR_W-1:0] m_addr,
    input  logic [1:0][DATA_W-1:0] m_wr_data,
    output logic [1:0]             m_ack,
    output logic [DATA_W-1:0]      m_rd_data,
    output logic                   m_timeout,
    output logic [ADDR_W-1:0]      s_addr,
    output logic                   s_wr,
    output logic [DATA_W-1:0]      s_wr_data,
    output logic                   s_rd,
    input  logic [DATA_W-1:0]      s_rd_data,
    input  logic                   s_rd_data_valid
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    generate
        if (TIMEOUT < 2) begin : g_timeout_check
            $error("athena_reg_arbiter: TIMEOUT must be at least 2");
        end
    endgenerate

    // Pointer 0 prefers requester 0, pointer 1 prefers requester 1.
    function automatic logic rr_pick(input logic ptr, input logic [1:0] req);
        logic pick;
        if (ptr == 1'b0) begin
            pick = req[0] ? 1'b0 : 1'b1;
        end else begin
            pick = req[1] ? 1'b1 : 1'b0;
        end
        return pick;
    endfunction

    state_t             state_r, state_s;
    logic               grant_r, grant_s;
    logic               wr_r, wr_s;
    logic               ptr_r, ptr_s;
    logic               to_flag_r, to_flag_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [ADDR_W-1:0]  s_addr_r, s_addr_s;
    logic [DATA_W-1:0]  s_wr_data_r, s_wr_data_s;
    logic               s_wr_r, s_wr_s;
    logic               s_rd_r, s_rd_s;
    logic [1:0]         m_ack_r, m_ack_s;
    logic               m_timeout_r, m_timeout_s;
    logic [DATA_W-1:0]  m_rd_data_r, m_rd_data_s;
    logic               pick_s;

    // Next-state and next-output computation; all outputs are registered from these.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        wr_s        = wr_r;
        ptr_s       = ptr_r;
        to_flag_s   = to_flag_r;
        cnt_s       = cnt_r;
        s_addr_s    = s_addr_r;
        s_wr_data_s = s_wr_data_r;
        m_rd_data_s = m_rd_data_r;
        s_wr_s      = 1'b0;
        s_rd_s      = 1'b0;
        pick_s      = rr_pick(ptr_r, m_req);
        case (state_r)
            ST_IDLE: begin
                if (|m_req) begin
                    grant_s     = pick_s;
                    wr_s        = m_wr[pick_s];
                    s_addr_s    = m_addr[pick_s];
                    s_wr_data_s = m_wr_data[pick_s];
                    s_wr_s      = m_wr[pick_s];
                    s_rd_s      = ~m_wr[pick_s];
                    state_s     = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (wr_r) begin
                    to_flag_s = 1'b0;
                    state_s   = ST_DONE;
                end else begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                // Data arriving on the last counted cycle still beats the timeout.
                if (s_rd_data_valid) begin
                    m_rd_data_s = s_rd_data;
                    to_flag_s   = 1'b0;
                    state_s     = ST_DONE;
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    m_rd_data_s = TIMEOUT_DATA;
                    to_flag_s   = 1'b1;
                    state_s     = ST_DONE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                ptr_s   = ~grant_r;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        m_ack_s     = (state_s == ST_DONE) ? (2'b01 << grant_s) : 2'b00;
        m_timeout_s = (state_s == ST_DONE) ? to_flag_s : 1'b0;
    end

    // State and output registers; reset abandons any transaction in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            grant_r     <= 1'b0;
            wr_r        <= 1'b0;
            ptr_r       <= 1'b0;
            to_flag_r   <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            s_addr_r    <= {ADDR_W{1'b0}};
            s_wr_data_r <= {DATA_W{1'b0}};
            s_wr_r      <= 1'b0;
            s_rd_r      <= 1'b0;
            m_ack_r     <= 2'b00;
            m_timeout_r <= 1'b0;
            m_rd_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            wr_r        <= wr_s;
            ptr_r       <= ptr_s;
            to_flag_r   <= to_flag_s;
            cnt_r       <= cnt_s;
            s_addr_r    <= s_addr_s;
            s_wr_data_r <= s_wr_data_s;
            s_wr_r      <= s_wr_s;
            s_rd_r      <= s_rd_s;
            m_ack_r     <= m_ack_s;
            m_timeout_r <= m_timeout_s;
            m_rd_data_r <= m_rd_data_s;
        end
    end

    assign m_ack     = m_ack_r;
    assign m_rd_data = m_rd_data_r;
    assign m_timeout = m_timeout_r;
    assign s_addr    = s_addr_r;
    assign s_wr      = s_wr_r;
    assign s_wr_data = s_wr_data_r;
    assign s_rd      = s_rd_r;

endmodule

// File: doc/athena_reg_arbiter.md
Name: athena_reg_arbiter

Overview:
- Shares one register-slave bus (the bus_if-style wr/wr_data/rd/rd_data/rd_data_valid port used by the DIP-switch and other settings registers) between two requesters.
- Requester 0 is the host bridge path. Requester 1 is the core-internal settings engine, which restores saved DIP and config values after load.
- Arbitration is round-robin with one outstanding transaction at a time. Reads have a timeout so a silent slave cannot hang either requester.

Parameters:
- ADDR_W, 32, address width carried to slave
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles from slave rd strobe to rd_data_valid before forced completion
- TIMEOUT_DATA, 32'hDEAD_BEEF, rd_data returned on timeout

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- m_req[1:0]  in  2  per-requester request; held high until m_ack
- m_wr[1:0]  in  2  1 = write, 0 = read; valid while m_req
- m_addr[1:0]  in  2xADDR_W  request address
- m_wr_data[1:0]  in  2xDATA_W  write data
- m_ack[1:0]  out  2  one-cycle completion pulse to the owning requester
- m_rd_data  out  DATA_W  read data, qualified by m_ack of a read
- m_timeout  out  1  high with m_ack when the read timed out
- s_addr  out  ADDR_W  slave address
- s_wr  out  1  slave write strobe, 1 cycle
- s_wr_data  out  DATA_W  slave write data
- s_rd  out  1  slave read strobe, 1 cycle
- s_rd_data  in  DATA_W  slave read data
- s_rd_data_valid  in  1  slave read-data qualifier

Behaviour:
- Reset:
  - State = IDLE.
  - All strobes (s_wr, s_rd, m_ack, m_timeout) = 0.
  - s_addr, s_wr_data, m_rd_data = 0.
  - Round-robin priority pointer = requester 0.
  - Reset mid-transaction aborts it: no m_ack is issued, and a late s_rd_data_valid after reset is ignored.
- States: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - If any m_req is high, grant per the pointer. Pointer = 0 prefers 0, then 1; pointer = 1 prefers 1, then 0.
  - Latch grant index, addr, wr and wr_data into registers, then go to ISSUE.
  - Requests are sampled only in IDLE. m_req changes outside IDLE are not observed.
- ISSUE (1 cycle):
  - Drive the latched s_addr and s_wr_data.
  - If write: assert s_wr for this cycle only, then go to DONE.
  - If read: assert s_rd for this cycle only, clear the timeout counter, then go to WAIT_RD.
- WAIT_RD:
  - On s_rd_data_valid: latch s_rd_data into m_rd_data, clear the timeout flag, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without valid: m_rd_data = TIMEOUT_DATA, set the timeout flag, go to DONE.
  - s_rd_data_valid in the same cycle as the timeout boundary: valid wins.
  - s_rd_data_valid outside WAIT_RD is ignored.
- DONE (1 cycle):
  - m_ack[grant] = 1 and m_timeout = flag.
  - Pointer = ~grant.
  - Go to IDLE.
  - The requester must drop m_req in the cycle after m_ack. A request still high in IDLE is treated as a new request.
- Latency, measured from the IDLE cycle that samples m_req to m_ack:
  - Write: 3 cycles (IDLE→ISSUE→DONE).
  - Read with a 1-cycle slave: 4 cycles.
  - Read timeout: 3 + TIMEOUT cycles.
- Output rules:
  - s_addr and s_wr_data hold their last value between transactions.
  - s_wr and s_rd are never asserted together, and at most one transaction is in flight.
  - m_rd_data holds until the next read completes. It is not cleared on writes.
- Simultaneous requests: both get served, alternating. Neither requester waits more than one other transaction.
- Widths: the timeout counter is $clog2(TIMEOUT+1) bits. TIMEOUT ≥ 2 is required; elaborate-time check.

Test Plan:
- Write, then read, from m0 only: write addr 0x0, data 0x0000_00A5 → s_wr pulses once with 0xA5, m_ack[0] 3 cycles after sampling. Following read with a 1-cycle slave → m_rd_data = 0xA5, m_ack[0], m_timeout = 0.
- Simultaneous m_req = 2'b11 from reset → m0 is served first, then m1. Repeat both requests → order alternates m1, m0. No starvation over 100 random cycles.
- Silent slave: m1 reads, s_rd_data_valid never asserted, TIMEOUT = 16 → m_ack[1] at 3 + 16 cycles with m_rd_data = 0xDEAD_BEEF and m_timeout = 1. Next good read has m_timeout = 0.
- Valid on the boundary: slave asserts valid exactly at counter = TIMEOUT-1 with data 0x1234 → m_rd_data = 0x1234, m_timeout = 0.
- Reset in WAIT_RD: assert reset for 1 cycle, then the slave returns valid → no m_ack, state IDLE, pointer = 0, all strobes 0.
- Held request: m0 keeps m_req high after m_ack while m1 also requests → m1 is granted next. m0's second transaction follows. s_wr and s_rd never overlap (assertion).
